// File: rtl/pong_frame_ctrl_if.sv
// Pixel position, paddle buttons and game-state bundle between the pong scan logic
// and pong_frame_ctrl. The master side drives position and buttons.
interface pong_frame_ctrl_if;
   logic [9:0] px;
   logic [9:0] py;
   logic       btn_l_up;
   logic       btn_l_dn;
   logic       btn_r_up;
   logic       btn_r_dn;
   logic [9:0] out_r;
   logic [9:0] out_g;
   logic [9:0] out_b;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [9:0] pad_l_y;
   logic [9:0] pad_r_y;
   logic [3:0] score_l;
   logic [3:0] score_r;
   logic       busy;
   logic       game_over;

   modport master (
      output px, py, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
      input  out_r, out_g, out_b, ball_x, ball_y, pad_l_y, pad_r_y,
      input  score_l, score_r, busy, game_over
   );

   modport slave (
      input  px, py, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
      output out_r, out_g, out_b, ball_x, ball_y, pad_l_y, pad_r_y,
      output score_l, score_r, busy, game_over
   );
endinterface

// File: rtl/pong_frame_ctrl.sv
// Pong game-state scheduler (one update per frame at vblank start) and pixel colour source.
// Define PONG_AI_PADDLE_EN to let the right paddle track the ball instead of btn_r_*.
module pong_frame_ctrl #(
   parameter int unsigned PAD_W      = 8,
   parameter int unsigned PAD_H      = 64,
   parameter int unsigned PAD_MARGIN = 16,
   parameter int unsigned PAD_SPEED  = 4,
   parameter int unsigned BALL_SZ    = 8,
   parameter int unsigned BALL_SPEED = 3,
   parameter int unsigned WIN_SCORE  = 9
) (
   input  logic             CLK25,
   input  logic             reset,
   pong_frame_ctrl_if.slave bus
);
   localparam logic [10:0] ScrW     = 11'd640;
   localparam logic [10:0] ScrH     = 11'd480;
   localparam logic [10:0] PadW     = 11'(PAD_W);
   localparam logic [10:0] PadH     = 11'(PAD_H);
   localparam logic [10:0] PadM     = 11'(PAD_MARGIN);
   localparam logic [10:0] PadSpd   = 11'(PAD_SPEED);
   localparam logic [10:0] BallSz   = 11'(BALL_SZ);
   localparam logic [10:0] BallSpd  = 11'(BALL_SPEED);
   localparam logic [3:0]  WinScore = 4'(WIN_SCORE);
   localparam logic [10:0] PadLEnd  = PadM + PadW;
   localparam logic [10:0] PadRx    = ScrW - PadM - PadW;
   localparam logic [10:0] PadREnd  = ScrW - PadM;
   localparam logic [10:0] PadYMax  = ScrH - PadH;
   localparam logic [10:0] BallYMax = ScrH - BallSz;
   localparam logic [9:0]  BallX0   = 10'(320 - BALL_SZ / 2);
   localparam logic [9:0]  BallY0   = 10'(240 - BALL_SZ / 2);
   localparam logic [9:0]  PadY0    = 10'(240 - PAD_H / 2);

   typedef enum logic [2:0] {StIdle, StPaddle, StBall, StCollide, StScore} state_t;

   state_t     state_q;
   logic [9:0] ball_x_q, ball_y_q, pad_l_y_q, pad_r_y_q, pix_q, pix_d;
   logic       dir_r_q, dir_d_q, busy_q, game_over_q;
   logic [3:0] score_l_q, score_r_q, score_l_inc, score_r_inc;
   logic [10:0] bx, by, ply, pry, pxe, pye;
   logic       trigger, hit_l, hit_r, miss_l, miss_r, in_ball, in_pad, in_net;
   logic       r_up, r_dn;

   // Arithmetic is done one bit wider so sums near the screen edge never wrap.
   assign bx  = {1'b0, ball_x_q};
   assign by  = {1'b0, ball_y_q};
   assign ply = {1'b0, pad_l_y_q};
   assign pry = {1'b0, pad_r_y_q};
   assign pxe = {1'b0, bus.px};
   assign pye = {1'b0, bus.py};

   assign trigger = (bus.px == 10'd0) && (bus.py == 10'd480);
   assign hit_l   = !dir_r_q && (bx <= PadLEnd) && (bx + BallSz > PadM) &&
                    (by < ply + PadH) && (by + BallSz > ply);
   assign hit_r   = dir_r_q && (bx + BallSz >= PadRx) && (bx < PadREnd) &&
                    (by < pry + PadH) && (by + BallSz > pry);
   assign miss_l  = !dir_r_q && (bx < BallSpd);
   assign miss_r  = dir_r_q && (bx + BallSz + BallSpd > ScrW);

   assign score_l_inc = (score_l_q == WinScore) ? score_l_q : score_l_q + 4'd1;
   assign score_r_inc = (score_r_q == WinScore) ? score_r_q : score_r_q + 4'd1;

`ifdef PONG_AI_PADDLE_EN
   logic [10:0] ball_c, pad_c;
   assign ball_c = by + (BallSz >> 1);
   assign pad_c  = pry + (PadH >> 1);
   assign r_up   = (ball_c + PadSpd < pad_c);
   assign r_dn   = (ball_c > pad_c + PadSpd);
`else
   assign r_up   = bus.btn_r_up;
   assign r_dn   = bus.btn_r_dn;
`endif

   function automatic logic [9:0] pad_step(input logic [10:0] y, input logic up, input logic dn);
      if (up && !dn) return 10'((y < PadSpd) ? 11'd0 : y - PadSpd);
      if (dn && !up) return 10'((y + PadSpd > PadYMax) ? PadYMax : y + PadSpd);
      return 10'(y);
   endfunction

   assign in_ball = (pxe >= bx) && (pxe < bx + BallSz) && (pye >= by) && (pye < by + BallSz);
   assign in_pad  = ((pxe >= PadM) && (pxe < PadLEnd) && (pye >= ply) && (pye < ply + PadH)) ||
                    ((pxe >= PadRx) && (pxe < PadREnd) && (pye >= pry) && (pye < pry + PadH));
   assign in_net  = (pxe >= 11'd318) && (pxe <= 11'd321) && !bus.py[4];

   always_comb begin
      pix_d = 10'h000;
      if ((pxe < ScrW) && (pye < ScrH)) begin
         if (in_ball || in_pad) pix_d = 10'h3FF;
         else if (in_net)       pix_d = 10'h200;
      end
   end

   always_ff @(posedge CLK25) begin
      if (reset) begin
         state_q     <= StIdle;
         ball_x_q    <= BallX0;
         ball_y_q    <= BallY0;
         dir_r_q     <= 1'b1;
         dir_d_q     <= 1'b1;
         pad_l_y_q   <= PadY0;
         pad_r_y_q   <= PadY0;
         score_l_q   <= 4'd0;
         score_r_q   <= 4'd0;
         busy_q      <= 1'b0;
         game_over_q <= 1'b0;
         pix_q       <= 10'h000;
      end else begin
         pix_q <= pix_d;
         unique case (state_q)
            StIdle: begin
               if (trigger) begin
                  state_q <= StPaddle;
                  busy_q  <= 1'b1;
               end
            end
            StPaddle: begin
               pad_l_y_q <= pad_step(ply, bus.btn_l_up, bus.btn_l_dn);
               pad_r_y_q <= pad_step(pry, r_up, r_dn);
               state_q   <= StBall;
            end
            StBall: begin
               if (!game_over_q) begin
                  ball_x_q <= dir_r_q ? 10'(bx + BallSpd) : 10'(bx - BallSpd);
                  if (!dir_d_q) begin
                     if (by < BallSpd) begin
                        ball_y_q <= 10'd0;
                        dir_d_q  <= 1'b1;
                     end else begin
                        ball_y_q <= 10'(by - BallSpd);
                     end
                  end else if (by + BallSz + BallSpd > ScrH) begin
                     ball_y_q <= 10'(BallYMax);
                     dir_d_q  <= 1'b0;
                  end else begin
                     ball_y_q <= 10'(by + BallSpd);
                  end
               end
               state_q <= StCollide;
            end
            StCollide: begin
               if (hit_l) begin
                  dir_r_q  <= 1'b1;
                  ball_x_q <= 10'(PadLEnd);
               end else if (hit_r) begin
                  dir_r_q  <= 1'b0;
                  ball_x_q <= 10'(PadRx - BallSz);
               end
               state_q <= StScore;
            end
            StScore: begin
               // The serve goes toward whoever just conceded.
               if (miss_l || miss_r) begin
                  ball_x_q <= BallX0;
                  ball_y_q <= BallY0;
                  dir_r_q  <= miss_r;
               end
               if (miss_l) begin
                  score_r_q <= score_r_inc;
                  if (score_r_inc == WinScore) game_over_q <= 1'b1;
               end else if (miss_r) begin
                  score_l_q <= score_l_inc;
                  if (score_l_inc == WinScore) game_over_q <= 1'b1;
               end
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_r     = pix_q;
   assign bus.out_g     = pix_q;
   assign bus.out_b     = pix_q;
   assign bus.ball_x    = ball_x_q;
   assign bus.ball_y    = ball_y_q;
   assign bus.pad_l_y   = pad_l_y_q;
   assign bus.pad_r_y   = pad_r_y_q;
   assign bus.score_l   = score_l_q;
   assign bus.score_r   = score_r_q;
   assign bus.busy      = busy_q;
   assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_pong_frame_ctrl.sv
// Self-checking bench for pong_frame_ctrl: per-frame game model plus render spot checks.
module tb_pong_frame_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pong_frame_ctrl_if bus ();

   pong_frame_ctrl dut (
      .CLK25 (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference game state: positions in pixels, directions as +1/-1.
   int mbx, mby, mdx, mdy, mpl, mpr, msl, msr;
   bit mgo;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mbx = 316; mby = 236; mdx = 1; mdy = 1;
      mpl = 208; mpr = 208; msl = 0; msr = 0; mgo = 0;
   endtask

   function automatic int pad_move(input int y, input bit up, input bit dn);
      if (up && !dn) return (y < 4) ? 0 : y - 4;
      if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
      return y;
   endfunction

   function automatic bit overlap_y(input int pad_y);
      return (mby < pad_y + 64) && (mby + 8 > pad_y);
   endfunction

   task automatic model_frame(input bit lu, input bit ld, input bit ru, input bit rd);
      mpl = pad_move(mpl, lu, ld);
      mpr = pad_move(mpr, ru, rd);
      if (!mgo) begin
         mbx += 3 * mdx;
         if (mdy < 0) begin
            if (mby < 3) begin mby = 0; mdy = 1; end
            else mby -= 3;
         end else begin
            if (mby + 11 > 480) begin mby = 472; mdy = -1; end
            else mby += 3;
         end
      end
      if (mdx < 0 && mbx <= 24 && mbx + 8 > 16 && overlap_y(mpl)) begin
         mdx = 1; mbx = 24;
      end else if (mdx > 0 && mbx + 8 >= 616 && mbx < 624 && overlap_y(mpr)) begin
         mdx = -1; mbx = 608;
      end
      if (mdx < 0 && mbx < 3) begin
         if (msr < 9) msr++;
         if (msr == 9) mgo = 1;
         mbx = 316; mby = 236; mdx = -1;
      end else if (mdx > 0 && mbx + 11 > 640) begin
         if (msl < 9) msl++;
         if (msl == 9) mgo = 1;
         mbx = 316; mby = 236; mdx = 1;
      end
   endtask

   function automatic int model_pix(input int x, input int y);
      if (x >= 640 || y >= 480) return 0;
      if (x >= mbx && x < mbx + 8 && y >= mby && y < mby + 8) return 'h3FF;
      if (x >= 16 && x < 24 && y >= mpl && y < mpl + 64) return 'h3FF;
      if (x >= 616 && x < 624 && y >= mpr && y < mpr + 64) return 'h3FF;
      if (x >= 318 && x <= 321 && ((y / 16) % 2) == 0) return 'h200;
      return 0;
   endfunction

   task automatic check_state();
      check("ball_x", bus.ball_x, mbx);
      check("ball_y", bus.ball_y, mby);
      check("pad_l_y", bus.pad_l_y, mpl);
      check("pad_r_y", bus.pad_r_y, mpr);
      check("score_l", bus.score_l, msl);
      check("score_r", bus.score_r, msr);
      check("game_over", bus.game_over, mgo);
   endtask

   // Trigger held two cycles: the second falls in PADDLE and must be ignored.
   task automatic run_frame(input bit lu, input bit ld, input bit ru, input bit rd);
      int bc = 0;
      @(negedge clk);
      bus.btn_l_up = lu; bus.btn_l_dn = ld; bus.btn_r_up = ru; bus.btn_r_dn = rd;
      bus.px = 10'd0; bus.py = 10'd480;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i == 1) begin bus.px = 10'd5; bus.py = 10'd481; end
         if (bus.busy === 1'b1) bc++;
      end
      model_frame(lu, ld, ru, rd);
      check("busy_cycles", bc, 4);
      check_state();
   endtask

   task automatic render_check(input int x, input int y);
      int e;
      if (x == 0 && y == 480) x = 1;
      @(negedge clk);
      bus.px = 10'(x); bus.py = 10'(y);
      @(negedge clk);
      e = model_pix(x, y);
      check("out_r", bus.out_r, e);
      check("out_g", bus.out_g, e);
      check("out_b", bus.out_b, e);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.px = 10'd700; bus.py = 10'd0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      check_state();
      check("rst_busy", bus.busy, 0);
      check("rst_out_r", bus.out_r, 0);
      check("rst_out_g", bus.out_g, 0);
      check("rst_out_b", bus.out_b, 0);
      reset = 1'b0;
   endtask

   initial begin
      bit lu, ld, ru, rd;
      reset = 1'b1;
      bus.px = 10'd700; bus.py = 10'd0;
      bus.btn_l_up = 1'b0; bus.btn_l_dn = 1'b0; bus.btn_r_up = 1'b0; bus.btn_r_dn = 1'b0;
      apply_reset();

      // First frame: ball 316->319, 236->239.
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);

      for (int f = 0; f < 60; f++) run_frame(1'b1, 1'b0, 1'b0, 1'b1);
      for (int f = 0; f < 10; f++) run_frame(1'b1, 1'b1, 1'b1, 1'b1);

      render_check(320, 0);
      render_check(700, 100);
      render_check(mbx, mby);
      render_check(mbx + 7, mby + 7);
      render_check(20, mpl + 5);
      render_check(620, mpr + 63);
      for (int k = 0; k < 30; k++) render_check($urandom_range(0, 799), $urandom_range(0, 524));

      lu = 0; ld = 0; ru = 0; rd = 0;
      for (int f = 0; f < 1500; f++) begin
         if (f % 8 == 0) begin
            lu = 1'($urandom_range(0, 1)); ld = 1'($urandom_range(0, 1));
            ru = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
         end
         run_frame(lu, ld, ru, rd);
         if (f % 50 == 0) render_check(mbx + $urandom_range(0, 10), mby + $urandom_range(0, 10));
      end

      // Pin both paddles at the top so points come quickly until someone reaches 9.
      for (int f = 0; f < 5000 && !mgo; f++) run_frame(1'b1, 1'b0, 1'b1, 1'b0);
      check("game_over_end", bus.game_over, mgo);
      for (int f = 0; f < 5; f++) run_frame(1'b0, 1'b1, 1'b0, 1'b1);
      render_check(mbx + 2, mby + 2);

      // Reset while the update sequence is mid-flight.
      @(negedge clk);
      bus.px = 10'd0; bus.py = 10'd480;
      @(negedge clk);
      bus.px = 10'd5; bus.py = 10'd481;
      @(negedge clk);
      check("busy_mid", bus.busy, 1);
      apply_reset();
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
